// File: rtl/wt_dcache_mem_adapter.sv
// -----------------------------------------------------------------------------
// wt_dcache_mem_adapter
//
// Sits between the write-through L1 data cache and a simple single-beat
// req/gnt/rvalid memory port. One cache request is accepted at a time and
// turned into one or more 64-bit memory beats. A single response pulse in the
// cache's return format follows the last beat.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   dc_req_i / dc_ack_o   cache request handshake (ack is combinational in IDLE)
//   dc_rtype_i            0 load, 1 store, 2 AMO, 3 reserved (answered locally)
//   dc_nc_i               non-cacheable load flag
//   dc_size_i             log2 access size in bytes
//   dc_amo_op_i           AMO opcode, passed through
//   dc_tid_i              transaction ID, echoed in the response
//   dc_paddr_i            physical address
//   dc_wdata_i            lane-aligned store/AMO data
//   dc_rtrn_*_o           one-cycle response: valid, type, tid, line data
//   mem_req_o / mem_gnt_i memory request handshake
//   mem_we_o, mem_amo_o, mem_amo_op_o, mem_addr_o, mem_be_o, mem_wdata_o
//                         beat attributes, held stable until granted
//   mem_rvalid_i          beat completion, mem_rdata_i its read data
// -----------------------------------------------------------------------------
module wt_dcache_mem_adapter #(
    parameter int unsigned LineWidth = 128,
    parameter int unsigned DataWidth = 64,
    parameter int unsigned TidWidth  = 2,
    parameter int unsigned PlenWidth = 56
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dc_req_i,
    output logic                 dc_ack_o,
    input  logic [1:0]           dc_rtype_i,
    input  logic                 dc_nc_i,
    input  logic [2:0]           dc_size_i,
    input  logic [3:0]           dc_amo_op_i,
    input  logic [TidWidth-1:0]  dc_tid_i,
    input  logic [PlenWidth-1:0] dc_paddr_i,
    input  logic [63:0]          dc_wdata_i,
    output logic                 dc_rtrn_vld_o,
    output logic [1:0]           dc_rtrn_type_o,
    output logic [TidWidth-1:0]  dc_rtrn_tid_o,
    output logic [LineWidth-1:0] dc_rtrn_data_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic                 mem_we_o,
    output logic                 mem_amo_o,
    output logic [3:0]           mem_amo_op_o,
    output logic [PlenWidth-1:0] mem_addr_o,
    output logic [7:0]           mem_be_o,
    output logic [63:0]          mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [63:0]          mem_rdata_i
);

    localparam int unsigned Beats = LineWidth / DataWidth;
    localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [PlenWidth-1:0] LineMask = ~PlenWidth'(LineWidth / 8 - 1);
    localparam logic [PlenWidth-1:0] WordMask = ~PlenWidth'(7);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RTRN} state_e;

    state_e                 state_q;
    logic [BeatW-1:0]       beat_q;
    logic [BeatW-1:0]       slot_q;
    logic                   fill_q;
    logic [1:0]             rtype_q;
    logic [TidWidth-1:0]    tid_q;
    logic [LineWidth-1:0]   line_q;
    logic [PlenWidth-1:0]   addr_q;
    logic [7:0]             be_q;
    logic [63:0]            wdata_q;
    logic                   we_q;
    logic                   amo_q;
    logic [3:0]             amo_op_q;

    // Request decode, evaluated on the incoming request fields
    logic                   req_fill;
    logic                   req_wr;
    logic [7:0]             be_mask;
    logic [7:0]             be_calc;
    logic [BeatW-1:0]       req_slot;
    logic [BeatW-1:0]       wr_slot;
    logic                   last_beat;

    always_comb begin
        req_fill = (dc_rtype_i == 2'd0) && !dc_nc_i;
        req_wr   = (dc_rtype_i == 2'd1) || (dc_rtype_i == 2'd2);
        case (dc_size_i)
            3'd0:    be_mask = 8'h01;
            3'd1:    be_mask = 8'h03;
            3'd2:    be_mask = 8'h0F;
            default: be_mask = 8'hFF;
        endcase
        // Shifting an 8-bit mask drops lanes past the word, i.e. truncation
        be_calc  = be_mask << dc_paddr_i[2:0];
        // Word slot inside the line for NC loads and AMOs
        req_slot = (Beats > 1) ? dc_paddr_i[3 +: BeatW] : '0;
    end

    assign wr_slot   = fill_q ? beat_q : slot_q;
    assign last_beat = !fill_q || (beat_q == BeatW'(Beats - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            slot_q   <= '0;
            fill_q   <= 1'b0;
            rtype_q  <= 2'd0;
            tid_q    <= '0;
            line_q   <= '0;
            addr_q   <= '0;
            be_q     <= 8'h00;
            wdata_q  <= 64'h0;
            we_q     <= 1'b0;
            amo_q    <= 1'b0;
            amo_op_q <= 4'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dc_req_i) begin
                        rtype_q <= dc_rtype_i;
                        tid_q   <= dc_tid_i;
                        fill_q  <= req_fill;
                        slot_q  <= req_slot;
                        beat_q  <= '0;
                        line_q  <= '0;
                        if (dc_rtype_i == 2'd3) begin
                            // Reserved type: answer as an empty load ack,
                            // memory-side outputs keep their last values
                            state_q <= RTRN;
                        end else begin
                            state_q  <= REQ;
                            addr_q   <= req_fill ? (dc_paddr_i & LineMask)
                                                 : (dc_paddr_i & WordMask);
                            be_q     <= req_wr ? be_calc : 8'hFF;
                            wdata_q  <= dc_wdata_i;
                            we_q     <= (dc_rtype_i == 2'd1);
                            amo_q    <= (dc_rtype_i == 2'd2);
                            amo_op_q <= dc_amo_op_i;
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt_i) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        // Store completions carry no data
                        if (rtype_q != 2'd1) begin
                            line_q[DataWidth*wr_slot +: DataWidth] <= mem_rdata_i;
                        end
                        if (last_beat) begin
                            state_q <= RTRN;
                        end else begin
                            beat_q  <= beat_q + 1'b1;
                            addr_q  <= addr_q + PlenWidth'(8);
                            state_q <= REQ;
                        end
                    end
                end
                RTRN: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dc_ack_o       = (state_q == IDLE) && dc_req_i;
    assign mem_req_o      = (state_q == REQ);
    assign mem_we_o       = we_q;
    assign mem_amo_o      = amo_q;
    assign mem_amo_op_o   = amo_op_q;
    assign mem_addr_o     = addr_q;
    assign mem_be_o       = be_q;
    assign mem_wdata_o    = wdata_q;

    // Response fields are only driven during the pulse so the port idles at 0
    assign dc_rtrn_vld_o  = (state_q == RTRN);
    assign dc_rtrn_type_o = !dc_rtrn_vld_o ? 2'd0 :
                            (rtype_q == 2'd3) ? 2'd0 : rtype_q;
    assign dc_rtrn_tid_o  = dc_rtrn_vld_o ? tid_q : '0;
    assign dc_rtrn_data_o = dc_rtrn_vld_o ? line_q : '0;

endmodule

// File: tb/tb_wt_dcache_mem_adapter.sv
module tb_wt_dcache_mem_adapter;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         dc_req_i;
    logic         dc_ack_o;
    logic [1:0]   dc_rtype_i;
    logic         dc_nc_i;
    logic [2:0]   dc_size_i;
    logic [3:0]   dc_amo_op_i;
    logic [1:0]   dc_tid_i;
    logic [55:0]  dc_paddr_i;
    logic [63:0]  dc_wdata_i;
    logic         dc_rtrn_vld_o;
    logic [1:0]   dc_rtrn_type_o;
    logic [1:0]   dc_rtrn_tid_o;
    logic [127:0] dc_rtrn_data_o;
    logic         mem_req_o;
    logic         mem_gnt_i;
    logic         mem_we_o;
    logic         mem_amo_o;
    logic [3:0]   mem_amo_op_o;
    logic [55:0]  mem_addr_o;
    logic [7:0]   mem_be_o;
    logic [63:0]  mem_wdata_o;
    logic         mem_rvalid_i;
    logic [63:0]  mem_rdata_i;

    wt_dcache_mem_adapter dut (
        .clk_i(clk), .rst_i(rst_i),
        .dc_req_i(dc_req_i), .dc_ack_o(dc_ack_o),
        .dc_rtype_i(dc_rtype_i), .dc_nc_i(dc_nc_i), .dc_size_i(dc_size_i),
        .dc_amo_op_i(dc_amo_op_i), .dc_tid_i(dc_tid_i), .dc_paddr_i(dc_paddr_i),
        .dc_wdata_i(dc_wdata_i),
        .dc_rtrn_vld_o(dc_rtrn_vld_o), .dc_rtrn_type_o(dc_rtrn_type_o),
        .dc_rtrn_tid_o(dc_rtrn_tid_o), .dc_rtrn_data_o(dc_rtrn_data_o),
        .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
        .mem_amo_o(mem_amo_o), .mem_amo_op_o(mem_amo_op_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int ack_cyc = 0;

    typedef struct {
        logic [1:0]   rtype;
        logic         nc;
        logic [2:0]   size;
        logic [3:0]   op;
        logic [1:0]   tid;
        logic [55:0]  paddr;
        logic [63:0]  wdata;
        logic [63:0]  rd0;
        logic [63:0]  rd1;
        int           stall;
        bit           spur;
        int           nbeats;
        logic [55:0]  eaddr;
        logic [7:0]   ebe;
        logic         ewe;
        logic         eamo;
        logic [1:0]   etype;
        logic [127:0] edata;
        int           elat;
    } vec_t;

    typedef struct {
        logic [1:0]   typ;
        logic [1:0]   tid;
        logic [127:0] data;
        int           lat;
    } rtrn_t;

    rtrn_t exp_q[$];
    vec_t  vecs[9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] rtype, input logic nc, input logic [2:0] size,
        input logic [3:0] op, input logic [1:0] tid, input logic [55:0] paddr,
        input logic [63:0] wdata, input logic [63:0] rd0, input logic [63:0] rd1,
        input int stall, input bit spur, input int nbeats, input logic [55:0] eaddr,
        input logic [7:0] ebe, input logic ewe, input logic eamo,
        input logic [1:0] etype, input logic [127:0] edata, input int elat);
        vec_t v;
        v.rtype = rtype; v.nc = nc; v.size = size; v.op = op; v.tid = tid;
        v.paddr = paddr; v.wdata = wdata; v.rd0 = rd0; v.rd1 = rd1;
        v.stall = stall; v.spur = spur; v.nbeats = nbeats; v.eaddr = eaddr;
        v.ebe = ebe; v.ewe = ewe; v.eamo = eamo; v.etype = etype;
        v.edata = edata; v.elat = elat;
        return v;
    endfunction

    // Response monitor: every pulse must match the oldest expectation
    always @(negedge clk) begin
        if (!rst_i && dc_rtrn_vld_o) begin
            if (exp_q.size() == 0) begin
                chk("rtrn_unexpected", {127'h0, dc_rtrn_vld_o}, 128'h0);
            end else begin
                rtrn_t e;
                e = exp_q.pop_front();
                chk("rtrn_type", 128'(dc_rtrn_type_o), 128'(e.typ));
                chk("rtrn_tid", 128'(dc_rtrn_tid_o), 128'(e.tid));
                chk("rtrn_data", dc_rtrn_data_o, e.data);
                chk("rtrn_latency", 128'(cyc - ack_cyc), 128'(e.lat));
            end
        end
    end

    task automatic check_beat(input string tag, input vec_t v, input logic [55:0] addr);
        chk({tag, "_addr"}, 128'(mem_addr_o), 128'(addr));
        chk({tag, "_be"}, 128'(mem_be_o), 128'(v.ebe));
        chk({tag, "_we"}, 128'(mem_we_o), 128'(v.ewe));
        chk({tag, "_amo"}, 128'(mem_amo_o), 128'(v.eamo));
        chk({tag, "_amo_op"}, 128'(mem_amo_op_o), 128'(v.op));
        if (v.ewe || v.eamo) chk({tag, "_wdata"}, 128'(mem_wdata_o), 128'(v.wdata));
    endtask

    task automatic run_txn(input int idx, input vec_t v);
        rtrn_t e;
        e.typ = v.etype; e.tid = v.tid; e.data = v.edata; e.lat = v.elat;
        exp_q.push_back(e);
        // Cycle 0: request, ack must be combinational
        dc_req_i = 1'b1; dc_rtype_i = v.rtype; dc_nc_i = v.nc; dc_size_i = v.size;
        dc_amo_op_i = v.op; dc_tid_i = v.tid; dc_paddr_i = v.paddr; dc_wdata_i = v.wdata;
        #1;
        chk("ack", 128'(dc_ack_o), 128'h1);
        ack_cyc = cyc;
        @(negedge clk);
        dc_req_i = 1'b0;
        for (int b = 0; b < v.nbeats; b++) begin
            logic [55:0] a;
            a = v.eaddr + 56'(8 * b);
            for (int k = 0; k < 20 && !mem_req_o; k++) @(negedge clk);
            chk("mem_req", 128'(mem_req_o), 128'h1);
            if (!mem_req_o) return;
            for (int s = 0; s < v.stall; s++) begin
                check_beat("stall", v, a);
                chk("stall_req", 128'(mem_req_o), 128'h1);
                mem_rvalid_i = v.spur && (s == 1);
                mem_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
                @(negedge clk);
            end
            mem_rvalid_i = 1'b0;
            check_beat("gnt", v, a);
            mem_gnt_i = 1'b1;
            @(negedge clk);
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i = (b == 0) ? v.rd0 : v.rd1;
            @(negedge clk);
            mem_rvalid_i = 1'b0;
        end
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        chk("rtrn_timeout", 128'(exp_q.size()), 128'h0);
        exp_q.delete();
        $display("txn %0d rtype=%0d nc=%0d paddr=%h tid=%0d beats=%0d done",
                 idx, v.rtype, v.nc, v.paddr, v.tid, v.nbeats);
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ack"}, 128'(dc_ack_o), 128'h0);
        chk({tag, "_rtrn_vld"}, 128'(dc_rtrn_vld_o), 128'h0);
        chk({tag, "_rtrn_type"}, 128'(dc_rtrn_type_o), 128'h0);
        chk({tag, "_rtrn_tid"}, 128'(dc_rtrn_tid_o), 128'h0);
        chk({tag, "_rtrn_data"}, dc_rtrn_data_o, 128'h0);
        chk({tag, "_mem_req"}, 128'(mem_req_o), 128'h0);
        chk({tag, "_we"}, 128'(mem_we_o), 128'h0);
        chk({tag, "_amo"}, 128'(mem_amo_o), 128'h0);
        chk({tag, "_addr"}, 128'(mem_addr_o), 128'h0);
        chk({tag, "_be"}, 128'(mem_be_o), 128'h0);
        chk({tag, "_wdata"}, 128'(mem_wdata_o), 128'h0);
    endtask

    initial begin
        // rtype nc size op tid paddr wdata rd0 rd1 stall spur | nbeats addr be we amo type data lat
        vecs[0] = mk(2'd0, 1'b0, 3'd3, 4'h0, 2'd1, 56'h8000_1018, 64'h0, 64'hA, 64'hB, 0, 0,
                     2, 56'h8000_1010, 8'hFF, 1'b0, 1'b0, 2'd0, {64'hB, 64'hA}, 5);
        vecs[1] = mk(2'd0, 1'b1, 3'd3, 4'h0, 2'd2, 56'h1008, 64'h0, 64'h1234, 64'h0, 0, 0,
                     1, 56'h1008, 8'hFF, 1'b0, 1'b0, 2'd0, {64'h1234, 64'h0}, 3);
        vecs[2] = mk(2'd1, 1'b0, 3'd1, 4'h0, 2'd3, 56'h2006, 64'h1234_0000_0000_0000, 64'hDEAD, 64'h0, 0, 0,
                     1, 56'h2000, 8'hC0, 1'b1, 1'b0, 2'd1, 128'h0, 3);
        vecs[3] = mk(2'd2, 1'b0, 3'd3, 4'h3, 2'd0, 56'h3000, 64'h77, 64'h55, 64'h0, 0, 0,
                     1, 56'h3000, 8'hFF, 1'b0, 1'b1, 2'd2, {64'h0, 64'h55}, 3);
        vecs[4] = mk(2'd0, 1'b1, 3'd2, 4'h0, 2'd1, 56'h4010, 64'h0, 64'hCAFE, 64'h0, 5, 1,
                     1, 56'h4010, 8'hFF, 1'b0, 1'b0, 2'd0, {64'h0, 64'hCAFE}, 8);
        vecs[5] = mk(2'd1, 1'b0, 3'd0, 4'h0, 2'd2, 56'h5003, 64'h0000_0000_AB00_0000, 64'h77, 64'h0, 0, 0,
                     1, 56'h5000, 8'h08, 1'b1, 1'b0, 2'd1, 128'h0, 3);
        vecs[6] = mk(2'd3, 1'b0, 3'd3, 4'h0, 2'd2, 56'h6000, 64'h0, 64'h0, 64'h0, 0, 0,
                     0, 56'h0, 8'h00, 1'b0, 1'b0, 2'd0, 128'h0, 1);
        vecs[7] = mk(2'd2, 1'b0, 3'd2, 4'hB, 2'd1, 56'h300C, 64'h0000_0001_0000_0000, 64'h99, 64'h0, 0, 0,
                     1, 56'h3008, 8'hF0, 1'b0, 1'b1, 2'd2, {64'h99, 64'h0}, 3);
        vecs[8] = mk(2'd0, 1'b0, 3'd3, 4'h0, 2'd3, 56'h100, 64'h0, 64'h11, 64'h22, 2, 1,
                     2, 56'h100, 8'hFF, 1'b0, 1'b0, 2'd0, {64'h22, 64'h11}, 9);

        rst_i = 1'b1; dc_req_i = 1'b0; dc_rtype_i = 2'd0; dc_nc_i = 1'b0; dc_size_i = 3'd0;
        dc_amo_op_i = 4'h0; dc_tid_i = 2'd0; dc_paddr_i = 56'h0; dc_wdata_i = 64'h0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 64'h0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

        // Reset while waiting for completion, then a late rvalid
        dc_req_i = 1'b1; dc_rtype_i = 2'd0; dc_nc_i = 1'b1; dc_size_i = 3'd3;
        dc_tid_i = 2'd1; dc_paddr_i = 56'h7000;
        @(negedge clk);
        dc_req_i = 1'b0;
        chk("rst_wait_req", 128'(mem_req_o), 128'h1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(negedge clk);
        check_all_zero("rst_wait");
        rst_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 64'hFFFF_FFFF;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_req", 128'(mem_req_o), 128'h0);
        $display("txn reset-in-wait sequence done");

        run_txn(9, vecs[3]);
        run_txn(10, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
